// File: rtl/rom_sequencer_if.sv
// Handshake and ROM bus bundle between rom_sequencer and its environment.
// master = sequencer side, slave = ROM / consumer / controller side.
interface rom_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic       done;

  modport master (
    input  start, abort, rom_data, char_ready,
    output rom_addr, char_out, char_valid, busy, done
  );

  modport slave (
    output start, abort, rom_data, char_ready,
    input  rom_addr, char_out, char_valid, busy, done
  );
endinterface

// File: rtl/rom_sequencer.sv
// Streams MSG_LEN characters from a combinational ROM, one per 2 cycles, first valid 2 cycles after start.
// Holds char_out/rom_addr while char_ready is low; abort and rst return to IDLE.
module rom_sequencer #(
  parameter int MSG_LEN     = 11,
  parameter bit STOP_ON_NUL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  rom_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);

  state_t     r_state;
  logic [3:0] r_addr;
  logic [7:0] r_char;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= 4'd0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr  <= 4'd0;
          r_valid <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_addr  <= 4'd0;
          end else if (STOP_ON_NUL && bus.rom_data == 8'h00) begin
            // NUL terminates the message without being presented
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_char  <= bus.rom_data;
            r_state <= SEND;
            r_valid <= 1'b1;
          end
        end
        SEND: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= 4'd0;
          end else if (bus.char_ready) begin
            r_valid <= 1'b0;
            if (r_addr == LAST_ADDR) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + 4'd1;
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_addr  <= 4'd0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_addr  <= 4'd0;
        end
      endcase
    end
  end

  assign bus.rom_addr   = r_addr;
  assign bus.char_out   = r_char;
  assign bus.char_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_rom_sequencer.sv
module tb_rom_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  rom_sequencer_if a ();
  rom_sequencer_if b ();

  rom_sequencer #(.MSG_LEN(11), .STOP_ON_NUL(1'b1)) u_a (.clk(clk), .rst(rst), .bus(a));
  rom_sequencer #(.MSG_LEN(16), .STOP_ON_NUL(1'b1)) u_b (.clk(clk), .rst(rst), .bus(b));

  logic [7:0] msg [11] = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45,
                           8'h45, 8'h52, 8'h49, 8'h4E, 8'h47};

  function automatic logic [7:0] rom(input logic [3:0] ad);
    case (ad)
      4'd0:  rom = 8'h45;
      4'd1:  rom = 8'h4E;
      4'd2:  rom = 8'h47;
      4'd3:  rom = 8'h49;
      4'd4:  rom = 8'h4E;
      4'd5:  rom = 8'h45;
      4'd6:  rom = 8'h45;
      4'd7:  rom = 8'h52;
      4'd8:  rom = 8'h49;
      4'd9:  rom = 8'h4E;
      4'd10: rom = 8'h47;
      4'd11: rom = 8'h00;
      default: rom = 8'h58;
    endcase
  endfunction

  assign a.rom_data = rom(a.rom_addr);
  assign b.rom_data = rom(b.rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full message on instance a; optional stall on character hold_idx and a stray start
  task automatic run_a(input int hold_idx, input int hold_n, input int restart_at,
                       output int ntx, output int ndone, output int lo_cyc);
    int k;
    int h;
    k = 0; h = 0; ntx = 0; ndone = 0; lo_cyc = -1;
    a.char_ready = 1'b1;
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    chk("start_busy", a.busy, 1);
    chk("start_addr", a.rom_addr, 0);
    chk("start_novalid", a.char_valid, 0);
    for (int i = 1; i < 80 && lo_cyc < 0; i++) begin
      step();
      a.start = (i == restart_at);
      if (i == 1) chk("latency2", a.char_valid, 1);
      if (a.done) ndone++;
      if (!a.busy) lo_cyc = i;
      a.char_ready = 1'b1;
      if (a.char_valid) begin
        if (k == hold_idx && h < hold_n) begin
          a.char_ready = 1'b0;
          h++;
          chk("hold", {a.rom_addr, a.char_out}, {4'd2, 8'h47});
        end else begin
          chk("char", {a.rom_addr, a.char_out}, {4'(k), msg[k]});
          ntx++;
          k++;
        end
      end
    end
    a.start = 1'b0;
  endtask

  int ntx, ndone, lo;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    a.start = 1'b1; a.abort = 1'b0; a.char_ready = 1'b1;
    b.start = 1'b0; b.abort = 1'b0; b.char_ready = 1'b1;
    step();
    step();
    a.start = 1'b0;
    chk("rst_vec", {a.rom_addr, a.char_out, a.char_valid, a.busy, a.done}, 15'h0);
    rst = 1'b0;
    step();
    chk("idle_busy", a.busy, 0);

    // plain message with a stray start mid-stream
    run_a(-1, 0, 6, ntx, ndone, lo);
    chk("msg_ntx", ntx, 11);
    chk("msg_done", ndone, 1);
    chk("msg_busy_lo", lo, 23);
    step(); step();
    chk("no_requeue", {a.busy, a.char_valid}, 0);

    // backpressure on third character
    run_a(2, 5, -1, ntx, ndone, lo);
    chk("bp_ntx", ntx, 11);
    chk("bp_done", ndone, 1);
    chk("bp_busy_lo", lo, 28);

    // abort during SEND of address 5
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    for (int i = 0; i < 40 && !(a.char_valid && a.rom_addr == 4'd5); i++) step();
    chk("reach_a5", {a.char_valid, a.rom_addr, a.char_out}, {1'b1, 4'd5, 8'h45});
    a.abort = 1'b1;
    step();
    a.abort = 1'b0;
    chk("abort_vec", {a.char_valid, a.busy, a.done, a.rom_addr}, 7'h0);
    step();
    chk("abort_nodone", {a.done, a.busy}, 0);
    run_a(-1, 0, -1, ntx, ndone, lo);
    chk("post_abort_ntx", ntx, 11);
    chk("post_abort_done", ndone, 1);

    // abort beats start in IDLE
    a.start = 1'b1; a.abort = 1'b1;
    step();
    a.start = 1'b0; a.abort = 1'b0;
    chk("abort_vs_start", a.busy, 0);
    step();
    chk("abort_vs_start2", a.char_valid, 0);

    // synchronous reset mid-message at address 7
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    for (int i = 0; i < 40 && a.rom_addr != 4'd7; i++) step();
    chk("reach_a7", a.rom_addr, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_vec", {a.rom_addr, a.char_out, a.char_valid, a.busy, a.done}, 15'h0);
    step(); step();
    chk("midrst_nodone", {a.done, a.busy}, 0);
    run_a(-1, 0, -1, ntx, ndone, lo);
    chk("post_rst_ntx", ntx, 11);
    chk("post_rst_done", ndone, 1);

    // MSG_LEN=16 with NUL at address 11
    begin
      int k, nd, nul;
      k = 0; nd = 0; nul = 0;
      b.start = 1'b1;
      step();
      b.start = 1'b0;
      for (int i = 0; i < 60 && (b.busy || i == 0); i++) begin
        step();
        if (b.done) nd++;
        if (b.char_valid) begin
          if (b.char_out == 8'h00) nul++;
          if (k < 11) chk("nul_char", b.char_out, msg[k]);
          k++;
        end
      end
      chk("nul_ntx", k, 11);
      chk("nul_done", nd, 1);
      chk("nul_never", nul, 0);
      chk("nul_idle", b.busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 Parameter MSG_LEN, default 11: number of ROM characters streamed per message (1..16).
REQ-002 Parameter STOP_ON_NUL, default 1: when 1, a fetched 8'h00 character ends the message early and is not presented.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 start  input  1: one-cycle request to stream a message; sampled only in IDLE.
REQ-006 abort  input  1: cancels an in-progress message.
REQ-007 rom_addr  output  4: address driven to the combinational character ROM.
REQ-008 rom_data  input  8: ROM character for rom_addr, valid in the same cycle.
REQ-009 char_out  output  8: registered character presented to the consumer.
REQ-010 char_valid  output  1: char_out holds a valid character.
REQ-011 char_ready  input  1: consumer accepts char_out this cycle when char_valid=1.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 done  output  1: one-cycle pulse after the message completes normally.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, SEND and DONE, all registered.
REQ-015 IDLE: start=1 -> FETCH next cycle with rom_addr=0; start=0 -> stay.
REQ-016 FETCH: capture rom_data into char_out and go to SEND; if STOP_ON_NUL=1 and rom_data=8'h00, go to DONE instead and leave char_out unchanged.
REQ-017 SEND: char_valid=1; char_out and rom_addr held stable until char_ready=1.
REQ-018 SEND with char_ready=1 and rom_addr=MSG_LEN-1 -> DONE; otherwise rom_addr+1 -> FETCH.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; rom_addr returns to 0.
REQ-020 Transfer occurs only in cycles where char_valid=1 and char_ready=1; char_ready is ignored otherwise.
REQ-021 Peak throughput: one character every 2 cycles; start-to-first-char_valid latency is 2 cycles.
REQ-022 start is ignored while busy=1; start does not queue.
REQ-023 abort=1 in FETCH, SEND or DONE -> IDLE next cycle. char_valid drops in that cycle, no done pulse, rom_addr=0. abort has priority over char_ready and completion.
REQ-024 abort and start asserted together in IDLE: abort wins; the FSM stays in IDLE.
REQ-025 rom_addr arithmetic is 4-bit. rom_addr never exceeds MSG_LEN-1, so it never wraps.
REQ-026 char_valid=1 only in SEND; done=1 only in DONE; busy=1 in FETCH, SEND and DONE.

Reset
REQ-027 rst=1 at any clock edge forces IDLE, rom_addr=0, char_out=8'h00, char_valid=0, busy=0, done=0; rst overrides start and abort.
REQ-028 rst asserted mid-message discards the message; no done pulse occurs; the next start restarts from address 0.

Verification
REQ-029 With the standard character ROM, MSG_LEN=11 and char_ready tied 1: pulse start -> 11 transfers 45,4E,47,49,4E,45,45,52,49,4E,47 hex, then one done pulse, busy low 23 cycles after start.
REQ-030 Backpressure: char_ready=0 for 5 cycles on the third character -> char_out stays 8'h47 with char_valid=1 and rom_addr=2 throughout; the sequence then resumes intact.
REQ-031 MSG_LEN=16, STOP_ON_NUL=1: the ROM returns 00 at address 11 -> exactly 11 transfers, then done; 8'h00 is never presented.
REQ-032 abort during SEND of address 5 -> next cycle IDLE, char_valid=0, no done; a new start streams again from 8'h45.
REQ-033 start pulsed again during a message -> no effect on output; sync rst at address 7 -> all outputs at reset values next cycle.
